// File: rtl/rr_mux_reg.sv
// Registered NUM_IN-way selector: round-robin or forced-select arbitration feeding
// a single-entry output register with valid/ready on every input and the output.
module rr_mux_reg #(
  parameter int WIDTH  = 3,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_IN*WIDTH-1:0]   in_data,
  input  logic [NUM_IN-1:0]         in_valid,
  output logic [NUM_IN-1:0]         in_ready,
  input  logic                      force_en,
  input  logic [SEL_W-1:0]          force_sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_src,
  output logic                      out_valid,
  input  logic                      out_ready
);

  // Handshake: a beat moves across an interface on a rising edge where valid and
  // ready are both 1; valid never waits for ready, and ready may depend on valid.

  logic             load;
  logic             grant_vld;
  logic [SEL_W-1:0] grant_idx;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] ptr_next;
  logic [WIDTH-1:0] sel_data;
  int               cand;

  assign load = ~out_valid | out_ready;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = 0;
    if (force_en) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (force_sel == SEL_W'(i) && in_valid[i]) begin
          grant_vld = 1'b1;
          grant_idx = SEL_W'(i);
        end
      end
    end else begin
      // Walk offsets from farthest to nearest so the channel closest to ptr wins.
      for (int k = NUM_IN - 1; k >= 0; k--) begin
        cand = int'(ptr) + k;
        if (cand >= NUM_IN) cand = cand - NUM_IN;
        for (int i = 0; i < NUM_IN; i++) begin
          if (i == cand && in_valid[i]) begin
            grant_vld = 1'b1;
            grant_idx = SEL_W'(i);
          end
        end
      end
    end
  end

  always_comb begin
    sel_data = '0;
    in_ready = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_idx == SEL_W'(i)) sel_data = in_data[i*WIDTH +: WIDTH];
      in_ready[i] = rst_n & load & grant_vld & (grant_idx == SEL_W'(i));
    end
  end

  always_comb begin
    ptr_next = grant_idx + SEL_W'(1);
    if (int'(grant_idx) == NUM_IN - 1) ptr_next = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= '0;
    end else if (load) begin
      if (grant_vld) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_src   <= grant_idx;
        if (!force_en) ptr <= ptr_next;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_reg.sv
// Directed bench for rr_mux_reg: a 4-channel instance and a 3-channel instance,
// checked with immediate assertions against hand-computed values.
module tb_rr_mux_reg;

  logic        clk;
  logic        rst_n;

  logic [11:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        force_en;
  logic [1:0]  force_sel;
  logic [2:0]  out_data;
  logic [1:0]  out_src;
  logic        out_valid;
  logic        out_ready;

  logic [8:0]  in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic        force_en3;
  logic [1:0]  force_sel3;
  logic [2:0]  out_data3;
  logic [1:0]  out_src3;
  logic        out_valid3;
  logic        out_ready3;

  int checks = 0;
  int errors = 0;

  rr_mux_reg #(.WIDTH(3), .NUM_IN(4), .SEL_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .force_en(force_en), .force_sel(force_sel),
    .out_data(out_data), .out_src(out_src), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  rr_mux_reg #(.WIDTH(3), .NUM_IN(3), .SEL_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .force_en(force_en3), .force_sel(force_sel3),
    .out_data(out_data3), .out_src(out_src3), .out_valid(out_valid3),
    .out_ready(out_ready3)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [1:0] s, input logic [2:0] d);
    chk({tag, "_valid"}, 32'(out_valid), 32'(v));
    chk({tag, "_src"},   32'(out_src),   32'(s));
    chk({tag, "_data"},  32'(out_data),  32'(d));
  endtask

  task automatic chk_out3(input string tag, input logic v, input logic [1:0] s, input logic [2:0] d);
    chk({tag, "_valid"}, 32'(out_valid3), 32'(v));
    chk({tag, "_src"},   32'(out_src3),   32'(s));
    chk({tag, "_data"},  32'(out_data3),  32'(d));
  endtask

  initial begin
    rst_n      = 1'b0;
    in_data    = {3'd7, 3'd6, 3'd5, 3'd4};
    in_valid   = 4'b1111;
    force_en   = 1'b0;
    force_sel  = 2'd0;
    out_ready  = 1'b1;
    in_data3   = {3'd6, 3'd5, 3'd4};
    in_valid3  = 3'b000;
    force_en3  = 1'b0;
    force_sel3 = 2'd0;
    out_ready3 = 1'b1;

    // reset holds everything clear even with requests pending
    #12;
    chk_out("rst", 1'b0, 2'd0, 3'd0);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    in_valid = 4'b0000;
    rst_n    = 1'b1;
    #1;
    chk("idle_in_ready", 32'(in_ready), 32'h0);
    step();
    chk("idle_valid", 32'(out_valid), 32'h0);

    // round-robin fairness from reset
    in_valid = 4'b1111;
    #1;
    chk("rr_ready0", 32'(in_ready), 32'b0001);
    step(); chk_out("rr0", 1'b1, 2'd0, 3'd4);
    chk("rr_ready1", 32'(in_ready), 32'b0010);
    step(); chk_out("rr1", 1'b1, 2'd1, 3'd5);
    step(); chk_out("rr2", 1'b1, 2'd2, 3'd6);
    step(); chk_out("rr3", 1'b1, 2'd3, 3'd7);
    step(); chk_out("rr4", 1'b1, 2'd0, 3'd4);
    chk("rr_ptr", 32'(dut.ptr), 32'd1);

    // backpressure: register holds, nothing granted
    out_ready = 1'b0;
    #1;
    chk("bp_ready", 32'(in_ready), 32'h0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk_out("bp_hold", 1'b1, 2'd0, 3'd4);
      chk("bp_hold_ready", 32'(in_ready), 32'h0);
      chk("bp_ptr", 32'(dut.ptr), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'b0010);
    step(); chk_out("bp_nobubble", 1'b1, 2'd1, 3'd5);

    // pointer skip and wrap: bring ptr to 3, then 0101 wraps to channel 0
    in_valid = 4'b0100;
    step(); chk_out("skip_a", 1'b1, 2'd2, 3'd6);
    chk("skip_ptr3", 32'(dut.ptr), 32'd3);
    in_valid = 4'b0101;
    #1;
    chk("wrap_ready", 32'(in_ready), 32'b0001);
    step(); chk_out("wrap", 1'b1, 2'd0, 3'd4);
    chk("wrap_ptr", 32'(dut.ptr), 32'd1);
    chk("wrap_ready2", 32'(in_ready), 32'b0100);
    step(); chk_out("wrap2", 1'b1, 2'd2, 3'd6);
    chk("wrap_ptr2", 32'(dut.ptr), 32'd3);

    // forced mode
    force_en  = 1'b1;
    force_sel = 2'd2;
    in_valid  = 4'b1111;
    #1;
    chk("force_ready", 32'(in_ready), 32'b0100);
    step(); chk_out("force0", 1'b1, 2'd2, 3'd6);
    step(); chk_out("force1", 1'b1, 2'd2, 3'd6);
    chk("force_ptr", 32'(dut.ptr), 32'd3);
    in_valid = 4'b1011;
    #1;
    chk("force_nogrant_ready", 32'(in_ready), 32'h0);
    step(); chk_out("force_drop", 1'b0, 2'd2, 3'd6);

    // leaving forced mode takes effect combinationally with ptr still at 3
    force_en = 1'b0;
    in_valid = 4'b1111;
    #1;
    chk("unforce_ready", 32'(in_ready), 32'b1000);
    step(); chk_out("unforce", 1'b1, 2'd3, 3'd7);
    chk("unforce_ptr", 32'(dut.ptr), 32'd0);

    // asynchronous reset while a beat is held
    #3;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 2'd0, 3'd0);
    chk("async_rst_ready", 32'(in_ready), 32'h0);
    chk("async_rst_ptr", 32'(dut.ptr), 32'd0);
    in_valid = 4'b0000;
    #2;
    rst_n = 1'b1;
    step();
    chk("post_rst_valid", 32'(out_valid), 32'h0);
    chk("post_rst_ready", 32'(in_ready), 32'h0);

    // three-channel instance: wrap at non-power-of-2 count
    in_valid3 = 3'b111;
    #1;
    chk("n3_ready0", 32'(in_ready3), 32'b001);
    step(); chk_out3("n3_0", 1'b1, 2'd0, 3'd4);
    step(); chk_out3("n3_1", 1'b1, 2'd1, 3'd5);
    step(); chk_out3("n3_2", 1'b1, 2'd2, 3'd6);
    chk("n3_ready_wrap", 32'(in_ready3), 32'b001);
    step(); chk_out3("n3_3", 1'b1, 2'd0, 3'd4);
    force_en3  = 1'b1;
    force_sel3 = 2'd3;
    #1;
    chk("n3_force3_ready", 32'(in_ready3), 32'h0);
    step(); chk_out3("n3_force3", 1'b0, 2'd0, 3'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
